// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return-address stack.
package pc_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_INC  = 3'd1,
        ACT_LOAD = 3'd2,
        ACT_CALL = 3'd3,
        ACT_RET  = 3'd4
    } act_e;

    // The level counter must represent 0..depth inclusive.
    function automatic int ras_level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push writes at level, pop reads level-1; only the level is reset.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4,
    localparam int LVL_W    = ras_level_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign full   = (level == LVL_W'(RAS_DEPTH));
    assign empty  = (level == '0);
    assign wr_idx = IDX_W'(level);
    assign rd_idx = IDX_W'(level - LVL_W'(1));
    assign top    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else if (push && !full) begin
            level <= level + LVL_W'(1);
        end else if (pop && !empty) begin
            level <= level - LVL_W'(1);
        end
    end

    // Contents are don't-care after reset, so storage has no reset term.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-address generator: increment, load, call/return via RAS,
// with stall and sticky stack-error flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                STEP       = 2,
    parameter int                RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int               LVL_W      = ras_level_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              call,
    input  logic              ret,
    input  logic              clear_err,
    input  logic [ADDR_W-1:0] new_count,
    output logic [ADDR_W-1:0] count,
    output logic [LVL_W-1:0]  ras_level,
    output logic              overflow,
    output logic              underflow
);

    act_e              act;
    logic              call_err;
    logic              ret_err;
    logic              ras_full;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] count_step;

    assign count_step = count + ADDR_W'(STEP);

    // One action per edge; a strobe that hits a full/empty stack becomes a hold.
    always_comb begin
        act      = ACT_HOLD;
        call_err = 1'b0;
        ret_err  = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (ras_empty) ret_err = 1'b1;
                else           act     = ACT_RET;
            end else if (call) begin
                if (ras_full) call_err = 1'b1;
                else          act      = ACT_CALL;
            end else if (load_pc) begin
                act = ACT_LOAD;
            end else if (inc_pc) begin
                act = ACT_INC;
            end
        end
    end

    pc_ret_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (act == ACT_CALL),
        .pop      (act == ACT_RET),
        .push_data(count_step),
        .top      (ras_top),
        .level    (ras_level),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_ADDR;
        end else begin
            case (act)
                ACT_INC:  count <= count_step;
                ACT_LOAD: count <= new_count;
                ACT_CALL: count <= new_count;
                ACT_RET:  count <= ras_top;
                default:  count <= count;
            endcase
        end
    end

    // Sticky flags: a same-cycle error event beats clear_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (call_err)       overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (ret_err)        underflow <= 1'b1;
            else if (clear_err) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=8, STEP=2, RAS_DEPTH=4, RESET_ADDR=0).
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset, stall, inc_pc, load_pc, call, ret, clear_err;
    logic [7:0] new_count;
    logic [7:0] count;
    logic [2:0] ras_level;
    logic       overflow, underflow;

    int errors = 0;
    int checks = 0;

    // Expected {count, ras_level, overflow, underflow}, pushed per driven cycle.
    logic [12:0] exp_q[$];
    logic [12:0] exp_v;
    logic [12:0] obs_v;

    // Reference model state.
    logic [7:0] m_count;
    logic [7:0] m_stk[4];
    int         m_lvl;
    logic       m_ovf, m_unf;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .inc_pc(inc_pc), .load_pc(load_pc),
        .call(call), .ret(ret), .clear_err(clear_err), .new_count(new_count),
        .count(count), .ras_level(ras_level), .overflow(overflow), .underflow(underflow)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Apply one cycle of strobes, advance the model, clock, and sample 1ns after the edge.
    task automatic drive(input logic rst, input logic stl, input logic inc, input logic ld,
                         input logic cl, input logic rt, input logic clr, input logic [7:0] nc);
        logic ev_o, ev_u;
        @(negedge clk);
        reset = rst; stall = stl; inc_pc = inc; load_pc = ld;
        call = cl; ret = rt; clear_err = clr; new_count = nc;
        ev_o = 1'b0; ev_u = 1'b0;
        if (rst) begin
            m_count = 8'h00; m_lvl = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (!stl) begin
                if (rt) begin
                    if (m_lvl == 0) ev_u = 1'b1;
                    else begin m_lvl--; m_count = m_stk[m_lvl]; end
                end else if (cl) begin
                    if (m_lvl == 4) ev_o = 1'b1;
                    else begin m_stk[m_lvl] = m_count + 8'd2; m_lvl++; m_count = nc; end
                end else if (ld) m_count = nc;
                else if (inc) m_count = m_count + 8'd2;
            end
            if (ev_o) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
            if (ev_u) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        end
        exp_q.push_back({m_count, 3'(m_lvl), m_ovf, m_unf});
        @(posedge clk);
        #1;
        obs_v = {count, ras_level, overflow, underflow};
    endtask

    task automatic test_reset();
        drive(1, 0, 1, 1, 1, 1, 0, 8'hAA);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_sb: got %h want %h", obs_v, exp_v); end
        checks++;
        if (obs_v !== 13'h0) begin errors++; $display("FAIL reset_state: got %h want 0000", obs_v); end
    endtask

    task automatic test_inc();
        logic [7:0] want [3];
        want[0] = 8'h02; want[1] = 8'h04; want[2] = 8'h06;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 8'h00);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL inc_sb[%0d]: got %h want %h", i, obs_v, exp_v); end
            checks++;
            if (count !== want[i] || ras_level !== 3'd0) begin
                errors++; $display("FAIL inc_count[%0d]: got %h/%0d want %h/0", i, count, ras_level, want[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        drive(0, 0, 0, 1, 0, 0, 0, 8'h10);
        exp_v = exp_q.pop_front();
        drive(0, 0, 0, 0, 1, 0, 0, 8'h40);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || count !== 8'h40 || ras_level !== 3'd1) begin
            errors++; $display("FAIL call: got %h/%0d want 40/1 (sb %h)", count, ras_level, exp_v);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || count !== 8'h12 || ras_level !== 3'd0) begin
            errors++; $display("FAIL ret: got %h/%0d want 12/0 (sb %h)", count, ras_level, exp_v);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [7:0] want [4];
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 8'h50 + 8'(i * 8));
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ovf_call_sb[%0d]: got %h want %h", i, obs_v, exp_v); end
        end
        checks++;
        if (count !== 8'h68 || ras_level !== 3'd4 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %h/%0d/%b want 68/4/1", count, ras_level, overflow);
        end
        want[0] = 8'h62; want[1] = 8'h5A; want[2] = 8'h52; want[3] = 8'h14;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v || count !== want[i]) begin
                errors++; $display("FAIL lifo_pop[%0d]: got %h want %h (sb %h)", i, count, want[i], exp_v);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || count !== 8'h14 || underflow !== 1'b1) begin
            errors++; $display("FAIL unf_flag: got %h/%b want 14/1", count, underflow);
        end
        // Error event in the same cycle as clear_err: set wins.
        drive(0, 0, 0, 0, 0, 1, 1, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || underflow !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL clr_vs_set: got ovf=%b unf=%b want 0/1", overflow, underflow);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || underflow !== 1'b0) begin
            errors++; $display("FAIL clear_err: got unf=%b want 0", underflow);
        end
    endtask

    task automatic test_wrap_stall();
        drive(0, 0, 0, 1, 0, 0, 0, 8'hFE);
        exp_v = exp_q.pop_front();
        drive(0, 0, 1, 0, 0, 0, 0, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || count !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL wrap: got %h ovf=%b unf=%b want 00/0/0", count, overflow, underflow);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 1, 0, 0, 8'h77);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v || count !== 8'h00 || ras_level !== 3'd0) begin
                errors++; $display("FAIL stall[%0d]: got %h/%0d want 00/0", i, count, ras_level);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 1, 0, 0, 0, 8'h20);
        exp_v = exp_q.pop_front();
        drive(0, 0, 0, 0, 1, 0, 0, 8'h30);
        exp_v = exp_q.pop_front();
        drive(0, 0, 0, 0, 1, 1, 0, 8'h99);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || count !== 8'h22 || ras_level !== 3'd0 || overflow || underflow) begin
            errors++; $display("FAIL call_ret_same: got %h/%0d/%b/%b want 22/0/0/0", count, ras_level, overflow, underflow);
        end
        drive(0, 0, 1, 1, 0, 0, 0, 8'h80);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || count !== 8'h80) begin
            errors++; $display("FAIL load_over_inc: got %h want 80", count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 8'h08 * 8'(i + 1));
            exp_v = exp_q.pop_front();
        end
        drive(1, 0, 0, 0, 1, 0, 0, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || obs_v !== 13'h0) begin
            errors++; $display("FAIL reset_mid: got %h want 0000", obs_v);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || underflow !== 1'b1 || count !== 8'h00) begin
            errors++; $display("FAIL ret_after_reset: got %h unf=%b want 00/1", count, underflow);
        end
    endtask

    task automatic test_random();
        logic [6:0] r;
        for (int i = 0; i < 300; i++) begin
            r = 7'($urandom_range(0, 127));
            drive(($urandom_range(0, 40) == 0), r[0] & r[1], r[2], r[3] & r[4], r[5] & ~r[6],
                  r[6] & r[1], ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random[%0d]: got %h want %h", i, obs_v, exp_v); end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
        call = 1'b0; ret = 1'b0; clear_err = 1'b0; new_count = 8'h00;
        m_count = 8'h00; m_lvl = 0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < 4; i++) m_stk[i] = 8'h00;
        test_reset();
        test_inc();
        test_call_ret();
        test_overflow_underflow();
        test_wrap_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain: got %0d left want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
